fetch_decode_stage: RTL and testbench
=====================================

Name: fetch_decode_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the RSA pipeline CPU.
- Sits directly downstream of the PC control unit:
  - consumes its PCNext, EndFlag and start;
  - issues req/ack reads to instruction memory;
  - presents the fetched instruction and its PC to decode.
- Handles decode stalls with a one-entry skid buffer, flushes on taken jumps and halts on END.

Parameters:
- ADDR_W, 32, PC/instruction-memory address width
- INSTR_W, 32, instruction width
- NOP_INSTR, 32'h0000_0000, value driven on instr_out when no valid instruction is present
- CNT_W, 16, width of the fetched-instruction counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  begin fetching; sampled in IDLE only
- pc_in  in  ADDR_W  next PC from PC control unit (PCNext)
- end_flag  in  1  END decoded (EndFlag)
- flush  in  1  taken jump; squash IF/ID and any in-flight fetch
- stall  in  1  decode cannot accept a new instruction this cycle
- imem_req  out  1  instruction-memory read request
- imem_addr  out  ADDR_W  read address; stable while imem_req=1
- imem_ack  in  1  read data valid; meaningful only while imem_req=1
- imem_rdata  in  INSTR_W  read data
- instr_out  out  INSTR_W  IF/ID instruction
- pc_out  out  ADDR_W  PC of instr_out
- valid_out  out  1  instr_out/pc_out hold a real instruction
- halted  out  1  END reached; sticky until reset
- fetch_count  out  CNT_W  number of instructions delivered to decode

Behaviour:
- Reset (reset=0 at a rising edge, any state): state=IDLE.
  - imem_req=0, imem_addr=0, instr_out=NOP_INSTR, pc_out=0, valid_out=0, halted=0, fetch_count=0.
  - Skid buffer and discard bit cleared.
  - An outstanding request is abandoned; memory must tolerate a dropped req.
- States: IDLE, REQ, HOLD, HALT.
- IDLE:
  - imem_req=0.
  - start=1 moves to REQ with req_pc <= pc_in.
- REQ:
  - imem_req=1, imem_addr=req_pc (registered, unchanged until ack).
  - Zero-wait memory (ack in the same cycle req is high) gives one instruction per cycle.
  - ack=1, discard=0, stall=0: IF/ID <= {imem_rdata, req_pc}; valid_out<=1; fetch_count+=1; req_pc <= pc_in; stay REQ.
  - ack=1, discard=0, stall=1: rdata/req_pc go into the skid buffer; state HOLD; IF/ID unchanged.
  - ack=1, discard=1: data dropped; discard<=0; req_pc <= pc_in.
  - ack=0, stall=0: valid_out<=0 (bubble).
  - ack=0, stall=1: IF/ID held.
- HOLD:
  - imem_req=0.
  - stall=0: skid moves to IF/ID; valid_out<=1; fetch_count+=1; req_pc <= pc_in; state REQ.
- flush=1 (any state except IDLE/HALT; priority over stall):
  - valid_out<=0, instr_out<=NOP_INSTR, skid buffer emptied.
  - HOLD -> REQ with req_pc <= pc_in.
  - REQ with ack=0: discard<=1. The current request completes per protocol (address stays stable) and its data is dropped.
  - REQ with ack=1: data dropped; next request uses pc_in.
- end_flag=1 (priority over flush and stall):
  - valid_out<=0, instr_out<=NOP_INSTR, halted<=1.
  - Any unacked request is held until ack, then dropped; then state HALT.
  - If no request is outstanding, go to HALT next cycle.
- HALT:
  - imem_req=0; all inputs except reset ignored.
  - halted=1, fetch_count frozen.
- fetch_count wraps modulo 2^CNT_W.
- Simultaneous ack and stall deassertion in HOLD: not possible, since no request is issued in HOLD.
- start while not IDLE: ignored.

Test Plan:
- Zero-wait memory (ack tied to req):
  - Stimulus: reset=0 for 2 cycles, then start with pc_in=0,4,8.
  - Required: imem_addr sequence 0,4,8 on consecutive cycles; pc_out 0,4,8 with valid_out=1 one cycle later; fetch_count=3.
- Wait states (ack two cycles after req):
  - Required: imem_addr=0x10 stable for 3 cycles; valid_out=0 bubbles between instructions; instr_out=imem_rdata when valid.
- Stall on ack (stall=1 when ack for pc=0x8):
  - Required: state HOLD, imem_req=0, pc_out stays at the previous PC; after stall drops, pc_out=0x8 and valid_out=1 with no re-fetch of 0x8.
- Flush during unacked request to 0x20, jump target pc_in=0x40:
  - Required: valid_out=0 next cycle; 0x20 data never appears on instr_out; next imem_addr=0x40.
- end_flag=1 mid-stream:
  - Required: halted=1, valid_out=0, imem_req=0 after any outstanding ack; start ignored; fetch_count frozen.
- reset=0 asserted while imem_req=1 and in HOLD:
  - Required: next cycle all outputs at reset values, state IDLE; reset has priority over start held high.

Source files
------------

// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: instruction fetch with req/ack memory, one-entry skid buffer, flush and halt, feeding the IF/ID register
module fetch_decode_stage #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               end_flag,
  input  logic               flush,
  input  logic               stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               valid_out,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d, skid_pc_q, skid_pc_d, pc_q, pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d, instr_q, instr_d;
  logic valid_q, valid_d, halted_q, halted_d, discard_q, discard_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign imem_req = state_q == REQ;
  assign imem_addr = req_pc_q;
  assign instr_out = instr_q;
  assign pc_out = pc_q;
  assign valid_out = valid_q;
  assign halted = halted_q;
  assign fetch_count = cnt_q;
  always_comb begin
    state_d = state_q;
    req_pc_d = req_pc_q;
    skid_pc_d = skid_pc_q;
    skid_instr_d = skid_instr_q;
    pc_d = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    halted_d = halted_q;
    discard_d = discard_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = REQ;
        req_pc_d = pc_in;
      end
      REQ: if (halted_q || end_flag) begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        halted_d = 1'b1;
        discard_d = 1'b0;
        state_d = imem_ack ? HALT : REQ;
      end else if (flush) begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        discard_d = !imem_ack;
        req_pc_d = imem_ack ? pc_in : req_pc_q;
      end else if (imem_ack && discard_q) begin
        discard_d = 1'b0;
        req_pc_d = pc_in;
        valid_d = stall ? valid_q : 1'b0;
      end else if (imem_ack && stall) begin
        skid_instr_d = imem_rdata;
        skid_pc_d = req_pc_q;
        state_d = HOLD;
      end else if (imem_ack) begin
        instr_d = imem_rdata;
        pc_d = req_pc_q;
        valid_d = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        req_pc_d = pc_in;
      end else if (!stall) begin
        valid_d = 1'b0;
      end
      HOLD: if (end_flag) begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        halted_d = 1'b1;
        state_d = HALT;
      end else if (flush) begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        req_pc_d = pc_in;
        state_d = REQ;
      end else if (!stall) begin
        instr_d = skid_instr_q;
        pc_d = skid_pc_q;
        valid_d = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        req_pc_d = pc_in;
        state_d = REQ;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      req_pc_q <= '0;
      skid_pc_q <= '0;
      skid_instr_q <= '0;
      pc_q <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      halted_q <= 1'b0;
      discard_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      req_pc_q <= req_pc_d;
      skid_pc_q <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      halted_q <= halted_d;
      discard_q <= discard_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb_fetch_decode_stage: directed self-checking bench for fetch_decode_stage
module tb_fetch_decode_stage;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, end_flag = 1'b0, flush = 1'b0, stall = 1'b0;
  logic [31:0] pc_in = '0, imem_addr, imem_rdata, instr_out, pc_out;
  logic imem_req, imem_ack, valid_out, halted, zw = 1'b0, ack_r = 1'b0;
  logic [15:0] fetch_count;
  int pass = 0, total = 0;
  assign imem_ack = zw ? imem_req : ack_r;
  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};
  always #5 clk = ~clk;
  fetch_decode_stage dut (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .end_flag(end_flag),
    .flush(flush), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_out(instr_out), .pc_out(pc_out),
    .valid_out(valid_out), .halted(halted), .fetch_count(fetch_count)
  );
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset;
    {start, end_flag, flush, stall, zw, ack_r} = '0;
    pc_in = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask
  task automatic test_reset;
    reset = 1'b0;
    tick();
    tick();
    total++; if ({imem_req, imem_addr} !== 33'h0) $display("FAIL reset_req got req=%b addr=%h exp 0/0", imem_req, imem_addr); else pass++;
    total++; if ({valid_out, instr_out, pc_out} !== 65'h0) $display("FAIL reset_ifid got v=%b i=%h p=%h exp 0", valid_out, instr_out, pc_out); else pass++;
    total++; if ({halted, fetch_count} !== 17'h0) $display("FAIL reset_misc got h=%b c=%0d exp 0/0", halted, fetch_count); else pass++;
    reset = 1'b1;
  endtask
  task automatic test_zero_wait;
    do_reset();
    zw = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL zw_addr0 got %b/%h exp 1/0", imem_req, imem_addr); else pass++;
    pc_in = 32'h4;
    tick();
    total++; if ({valid_out, pc_out, instr_out, imem_addr} !== {1'b1, 32'h0, 32'hC0DE0000, 32'h4}) $display("FAIL zw_pc0 got v=%b p=%h i=%h a=%h exp 1/0/c0de0000/4", valid_out, pc_out, instr_out, imem_addr); else pass++;
    pc_in = 32'h8;
    tick();
    total++; if ({valid_out, pc_out, imem_addr} !== {1'b1, 32'h4, 32'h8}) $display("FAIL zw_pc4 got v=%b p=%h a=%h exp 1/4/8", valid_out, pc_out, imem_addr); else pass++;
    pc_in = 32'hC;
    tick();
    zw = 1'b0;
    total++; if ({valid_out, pc_out, instr_out} !== {1'b1, 32'h8, 32'hC0DE0008}) $display("FAIL zw_pc8 got v=%b p=%h i=%h exp 1/8/c0de0008", valid_out, pc_out, instr_out); else pass++;
    total++; if (fetch_count !== 16'd3) $display("FAIL zw_count got %0d exp 3", fetch_count); else pass++;
  endtask
  task automatic test_wait_states;
    do_reset();
    pc_in = 32'h10;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if ({imem_req, imem_addr} !== {1'b1, 32'h10}) $display("FAIL ws_addr_c0 got %b/%h exp 1/10", imem_req, imem_addr); else pass++;
    tick();
    total++; if ({imem_req, imem_addr, valid_out} !== {1'b1, 32'h10, 1'b0}) $display("FAIL ws_addr_c1 got %b/%h v=%b exp 1/10/0", imem_req, imem_addr, valid_out); else pass++;
    tick();
    pc_in = 32'h14;
    ack_r = 1'b1;
    total++; if ({imem_req, imem_addr, valid_out} !== {1'b1, 32'h10, 1'b0}) $display("FAIL ws_addr_c2 got %b/%h v=%b exp 1/10/0", imem_req, imem_addr, valid_out); else pass++;
    tick();
    ack_r = 1'b0;
    total++; if ({valid_out, pc_out, instr_out, imem_addr} !== {1'b1, 32'h10, 32'hC0DE0010, 32'h14}) $display("FAIL ws_deliver got v=%b p=%h i=%h a=%h exp 1/10/c0de0010/14", valid_out, pc_out, instr_out, imem_addr); else pass++;
    tick();
    total++; if ({valid_out, fetch_count} !== {1'b0, 16'd1}) $display("FAIL ws_bubble got v=%b c=%0d exp 0/1", valid_out, fetch_count); else pass++;
  endtask
  task automatic test_stall;
    do_reset();
    zw = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    pc_in = 32'h4;
    tick();
    pc_in = 32'h8;
    tick();
    pc_in = 32'hC;
    stall = 1'b1;
    tick();
    total++; if ({imem_req, valid_out, pc_out, fetch_count} !== {1'b0, 1'b1, 32'h4, 16'd2}) $display("FAIL stall_hold got r=%b v=%b p=%h c=%0d exp 0/1/4/2", imem_req, valid_out, pc_out, fetch_count); else pass++;
    tick();
    total++; if ({imem_req, pc_out} !== {1'b0, 32'h4}) $display("FAIL stall_hold2 got r=%b p=%h exp 0/4", imem_req, pc_out); else pass++;
    stall = 1'b0;
    zw = 1'b0;
    tick();
    total++; if ({valid_out, pc_out, instr_out, fetch_count} !== {1'b1, 32'h8, 32'hC0DE0008, 16'd3}) $display("FAIL stall_release got v=%b p=%h i=%h c=%0d exp 1/8/c0de0008/3", valid_out, pc_out, instr_out, fetch_count); else pass++;
    total++; if ({imem_req, imem_addr} !== {1'b1, 32'hC}) $display("FAIL stall_nofetch got %b/%h exp 1/c", imem_req, imem_addr); else pass++;
  endtask
  task automatic test_flush;
    do_reset();
    pc_in = 32'h1C;
    start = 1'b1;
    tick();
    start = 1'b0;
    ack_r = 1'b1;
    pc_in = 32'h20;
    tick();
    ack_r = 1'b0;
    total++; if ({valid_out, pc_out, imem_addr} !== {1'b1, 32'h1C, 32'h20}) $display("FAIL flush_pre got v=%b p=%h a=%h exp 1/1c/20", valid_out, pc_out, imem_addr); else pass++;
    flush = 1'b1;
    pc_in = 32'h40;
    tick();
    flush = 1'b0;
    total++; if ({valid_out, instr_out, imem_req, imem_addr} !== {1'b0, 32'h0, 1'b1, 32'h20}) $display("FAIL flush_squash got v=%b i=%h r=%b a=%h exp 0/0/1/20", valid_out, instr_out, imem_req, imem_addr); else pass++;
    ack_r = 1'b1;
    tick();
    ack_r = 1'b0;
    total++; if ({valid_out, instr_out, imem_addr, fetch_count} !== {1'b0, 32'h0, 32'h40, 16'd1}) $display("FAIL flush_drop got v=%b i=%h a=%h c=%0d exp 0/0/40/1", valid_out, instr_out, imem_addr, fetch_count); else pass++;
    ack_r = 1'b1;
    pc_in = 32'h44;
    tick();
    ack_r = 1'b0;
    total++; if ({valid_out, pc_out, instr_out} !== {1'b1, 32'h40, 32'hC0DE0040}) $display("FAIL flush_target got v=%b p=%h i=%h exp 1/40/c0de0040", valid_out, pc_out, instr_out); else pass++;
  endtask
  task automatic test_end;
    do_reset();
    pc_in = 32'h50;
    start = 1'b1;
    tick();
    start = 1'b0;
    ack_r = 1'b1;
    pc_in = 32'h54;
    tick();
    ack_r = 1'b0;
    end_flag = 1'b1;
    tick();
    end_flag = 1'b0;
    total++; if ({halted, valid_out, instr_out, imem_req, imem_addr} !== {1'b1, 1'b0, 32'h0, 1'b1, 32'h54}) $display("FAIL end_pending got h=%b v=%b i=%h r=%b a=%h exp 1/0/0/1/54", halted, valid_out, instr_out, imem_req, imem_addr); else pass++;
    tick();
    ack_r = 1'b1;
    tick();
    ack_r = 1'b0;
    total++; if ({imem_req, halted, valid_out, fetch_count} !== {1'b0, 1'b1, 1'b0, 16'd1}) $display("FAIL end_halt got r=%b h=%b v=%b c=%0d exp 0/1/0/1", imem_req, halted, valid_out, fetch_count); else pass++;
    start = 1'b1;
    zw = 1'b1;
    tick();
    tick();
    start = 1'b0;
    total++; if ({imem_req, halted, valid_out, fetch_count} !== {1'b0, 1'b1, 1'b0, 16'd1}) $display("FAIL end_frozen got r=%b h=%b v=%b c=%0d exp 0/1/0/1", imem_req, halted, valid_out, fetch_count); else pass++;
  endtask
  task automatic test_end_in_hold;
    do_reset();
    zw = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    stall = 1'b1;
    pc_in = 32'h4;
    tick();
    end_flag = 1'b1;
    tick();
    end_flag = 1'b0;
    stall = 1'b0;
    tick();
    total++; if ({imem_req, halted, valid_out, fetch_count} !== {1'b0, 1'b1, 1'b0, 16'd0}) $display("FAIL end_hold got r=%b h=%b v=%b c=%0d exp 0/1/0/0", imem_req, halted, valid_out, fetch_count); else pass++;
  endtask
  task automatic test_reset_midrun;
    do_reset();
    zw = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    pc_in = 32'h4;
    tick();
    pc_in = 32'h8;
    stall = 1'b1;
    tick();
    total++; if ({imem_req, valid_out, pc_out} !== {1'b0, 1'b1, 32'h0}) $display("FAIL rst_prehold got r=%b v=%b p=%h exp 0/1/0", imem_req, valid_out, pc_out); else pass++;
    reset = 1'b0;
    start = 1'b1;
    tick();
    total++; if ({imem_req, imem_addr, valid_out, instr_out, pc_out, halted, fetch_count} !== 83'h0) $display("FAIL rst_hold got r=%b a=%h v=%b i=%h p=%h h=%b c=%0d exp all 0", imem_req, imem_addr, valid_out, instr_out, pc_out, halted, fetch_count); else pass++;
    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    zw = 1'b0;
    pc_in = 32'h60;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if ({imem_req, imem_addr} !== {1'b1, 32'h60}) $display("FAIL rst_prereq got %b/%h exp 1/60", imem_req, imem_addr); else pass++;
    reset = 1'b0;
    start = 1'b1;
    tick();
    tick();
    total++; if ({imem_req, imem_addr, valid_out, halted, fetch_count} !== 51'h0) $display("FAIL rst_req got r=%b a=%h v=%b h=%b c=%0d exp all 0", imem_req, imem_addr, valid_out, halted, fetch_count); else pass++;
    reset = 1'b1;
    start = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_flush();
    test_end();
    test_end_in_hold();
    test_reset_midrun();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
